ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative multiply/divide unit in the EX stage, consuming the ID/EX bundle on the read side of that pipeline register. It executes MULT/MULTU/DIV/DIVU over 34 cycles and owns the architectural HI/LO registers. It holds the front of the pipeline with a stall signal until the result is committed. MTHI/MTLO complete in one cycle.

## Interface
- ITER, 32: iteration count, equal to the operand width.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_E  in  1  valid mul/div/move op present in the EX stage this cycle.
- op_E  in  3  000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO.
- srcA_E  in  32  rs operand (multiplicand/dividend, or MTHI/MTLO data).
- srcB_E  in  32  rt operand (multiplier/divisor).
- flush_E  in  1  abort any in-flight operation.
- stall  out  1  hold IF/ID/EX. Combinational: busy | (start_E & idle & op in MULT..DIVU) | (start_E & op in MTHI/MTLO & ~idle).
- busy  out  1  registered, high while an operation is in flight.
- done  out  1  one-cycle pulse after the HI/LO commit of a mul/div.
- div0  out  1  pulses together with done when a divide had srcB = 0.
- hi, lo  out  32 each  architectural HI/LO.
- Reset: all registered outputs are 0 and the state is IDLE.

## Operation
- States: IDLE, RUN, COMMIT.
- IDLE, with start_E and a mul/div op:
  - Capture |srcA| and |srcB|; signed ops use two's-complement magnitude, unsigned ops pass through.
  - Record result signs: product sign = a31^b31; quotient sign = a31^b31; remainder sign = a31.
  - Set count = 0 and go to RUN.
- IDLE, with start_E and MTHI: hi <= srcA_E at the next edge. MTLO writes lo the same way. No stall.
- RUN, multiply: shift-add, 1 multiplier bit per cycle, into a 64-bit accumulator.
- RUN, divide: restoring division, 1 quotient bit per cycle.
- RUN transitions: count increments; after ITER cycles go to COMMIT.
- COMMIT:
  - Apply sign fixes. Multiply writes {hi,lo} = product. Divide writes lo = quotient, hi = remainder.
  - Pulse done (and div0 if applicable) for the following cycle. Return to IDLE.
- Divide by zero, forced result: lo = 32'hFFFF_FFFF, hi = srcA_E as captured (raw, no sign fix); div0 = 1.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo = 0x8000_0000, hi = 0 (natural wrap, no trap).
- flush_E in RUN or COMMIT: go to IDLE at the next edge. HI/LO are unchanged; no done.
- Ops while non-IDLE:
  - start_E with a new mul/div is not accepted (upstream is stalled and holds it).
  - MTHI/MTLO are held by stall until IDLE.
- rst mid-operation: immediate return to IDLE; hi = lo = 0.

## Timing
- Accept at edge N (IDLE→RUN); RUN covers edges N+1..N+32; edge N+33 performs COMMIT; done is high in the cycle after N+33.
- HI/LO change only at the commit edge N+33, or at the single MTHI/MTLO edge.
- stall is high from the accept cycle through the COMMIT cycle (34 cycles), then low the cycle done is high, so a dependent MFHI/MFLO in the next instruction reads the new value.
- Back-to-back mul/div: a second op can be accepted in the done cycle (state IDLE).
- flush_E and COMMIT in the same cycle: flush wins, no HI/LO write.

## Structure
- Shared package muldiv_pkg: op encodings, state enum {IDLE, RUN, COMMIT}, ITER = 32.
- One sub-module, signed_mag: combinational abs/conditional-negate, parameterized width. Used for operand magnitudes and for result sign fix (32- and 64-bit instances).
- Top module contains the FSM, counter, accumulator/remainder datapath and the HI/LO registers.

## Test plan
- Reset then MULT 0xFFFF_FFFF × 0x0000_0002 -> after 34 stall cycles hi = 0xFFFF_FFFF, lo = 0xFFFF_FFFE; done pulses once.
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF -> hi = 0xFFFF_FFFE, lo = 0x0000_0001.
- DIV -7 / 2 -> lo = 0xFFFF_FFFD (-3), hi = 0xFFFF_FFFF (-1). Then DIVU 7 / 0 -> lo = 0xFFFF_FFFF, hi = 7, div0 = 1 with done.
- MULT started, flush_E at cycle 10 -> IDLE next edge, hi/lo keep prior values, no done, stall drops.
- MTHI 0x1234 in IDLE -> hi = 0x1234 next edge, stall never high. MTLO issued during RUN -> stalled until IDLE, then lo written.
- rst asserted mid-RUN (asynchronous, between edges) -> busy = 0, hi = lo = 0 immediately; a subsequent MULT 3 × 5 -> lo = 15.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit:
// op encodings, FSM states and iteration count.
package muldiv_pkg;

    localparam int unsigned ITER = 32;

    typedef enum logic [2:0] {
        OpNone  = 3'b000,
        OpMult  = 3'b001,
        OpMultu = 3'b010,
        OpDiv   = 3'b011,
        OpDivu  = 3'b100,
        OpMthi  = 3'b101,
        OpMtlo  = 3'b110
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StCommit
    } state_e;

    function automatic logic is_muldiv(logic [2:0] op);
        return (op >= OpMult) && (op <= OpDivu);
    endfunction

    function automatic logic is_move(logic [2:0] op);
        return (op == OpMthi) || (op == OpMtlo);
    endfunction

    function automatic logic is_signed_op(logic [2:0] op);
        return (op == OpMult) || (op == OpDiv);
    endfunction

    function automatic logic is_div_op(logic [2:0] op);
        return (op == OpDiv) || (op == OpDivu);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX-side bundle for the multiply/divide unit: request from the pipeline,
// stall/status and architectural HI/LO back to it.
interface ex_muldiv_if;

    logic        start_E;
    logic [2:0]  op_E;
    logic [31:0] srcA_E;
    logic [31:0] srcB_E;
    logic        flush_E;
    logic        stall;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start_E, op_E, srcA_E, srcB_E, flush_E,
        input  stall, busy, done, div0, hi, lo
    );

    modport slave (
        input  start_E, op_E, srcA_E, srcB_E, flush_E,
        output stall, busy, done, div0, hi, lo
    );

endinterface

// File: rtl/signed_mag.sv
// Conditional two's-complement negate: absolute value when negate = sign bit,
// sign restoration when negate = result sign.
module signed_mag #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] value,
    input  logic             negate,
    output logic [Width-1:0] result
);

    assign result = negate ? (~value + Width'(1)) : value;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO; stalls the
// front of the pipeline from accept through commit.
module ex_muldiv
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);

    localparam int unsigned CntW = $clog2(ITER);

    state_e          state_q, state_d;
    logic [CntW-1:0] count_q;
    logic [63:0]     acc_q;
    logic [31:0]     opnd_q;
    logic [31:0]     raw_a_q;
    logic            is_div_q, neg_lo_q, neg_hi_q, div0_flag_q;
    logic [31:0]     hi_q, lo_q;
    logic            done_q, div0_q;

    logic        idle, accept, mthi_wr, mtlo_wr, commit, op_signed, op_div;
    logic [31:0] mag_a, mag_b, quo_fix, rem_fix;
    logic [63:0] prod_fix, mul_next, div_next;
    logic [32:0] mul_sum, div_shift, div_diff;

    assign idle      = (state_q == StIdle);
    assign op_signed = is_signed_op(bus.op_E);
    assign op_div    = is_div_op(bus.op_E);
    assign accept    = idle && bus.start_E && is_muldiv(bus.op_E);
    assign mthi_wr   = idle && bus.start_E && (bus.op_E == OpMthi);
    assign mtlo_wr   = idle && bus.start_E && (bus.op_E == OpMtlo);
    assign commit    = (state_q == StCommit) && !bus.flush_E;

    signed_mag #(.Width(32)) u_mag_a (
        .value  (bus.srcA_E),
        .negate (op_signed && bus.srcA_E[31]),
        .result (mag_a)
    );

    signed_mag #(.Width(32)) u_mag_b (
        .value  (bus.srcB_E),
        .negate (op_signed && bus.srcB_E[31]),
        .result (mag_b)
    );

    signed_mag #(.Width(64)) u_fix_prod (
        .value  (acc_q),
        .negate (neg_lo_q),
        .result (prod_fix)
    );

    signed_mag #(.Width(32)) u_fix_quo (
        .value  (acc_q[31:0]),
        .negate (neg_lo_q),
        .result (quo_fix)
    );

    signed_mag #(.Width(32)) u_fix_rem (
        .value  (acc_q[63:32]),
        .negate (neg_hi_q),
        .result (rem_fix)
    );

    // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Divide: acc = {remainder, dividend/quotient}; restoring trial subtract.
    assign div_shift = {acc_q[63:32], acc_q[31]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                    : {div_diff[31:0], acc_q[30:0], 1'b1};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StRun;
            StRun: begin
                if (bus.flush_E)                       state_d = StIdle;
                else if (count_q == CntW'(ITER - 1))   state_d = StCommit;
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            raw_a_q     <= '0;
            is_div_q    <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            div0_flag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                count_q     <= '0;
                acc_q       <= {32'd0, op_div ? mag_a : mag_b};
                opnd_q      <= op_div ? mag_b : mag_a;
                raw_a_q     <= bus.srcA_E;
                is_div_q    <= op_div;
                neg_lo_q    <= op_signed && (bus.srcA_E[31] ^ bus.srcB_E[31]);
                neg_hi_q    <= op_signed && bus.srcA_E[31];
                div0_flag_q <= op_div && (bus.srcB_E == 32'd0);
            end else if (state_q == StRun) begin
                count_q <= count_q + CntW'(1);
                acc_q   <= is_div_q ? div_next : mul_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            div0_q <= 1'b0;
        end else begin
            done_q <= commit;
            div0_q <= commit && div0_flag_q;
            if (commit) begin
                if (!is_div_q) begin
                    {hi_q, lo_q} <= prod_fix;
                end else if (div0_flag_q) begin
                    hi_q <= raw_a_q;
                    lo_q <= 32'hFFFF_FFFF;
                end else begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end
            end else if (mthi_wr) begin
                hi_q <= bus.srcA_E;
            end else if (mtlo_wr) begin
                lo_q <= bus.srcA_E;
            end
        end
    end

    assign bus.busy  = !idle;
    assign bus.stall = !idle || accept || (bus.start_E && is_move(bus.op_E) && !idle);
    assign bus.done  = done_q;
    assign bus.div0  = div0_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, hand-written
// flush/move/reset/back-to-back sequences, and random ops vs an arithmetic model.
module tb_ex_muldiv;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ex_muldiv_if bus();

    ex_muldiv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] m_hi, m_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        d0;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Reference: plain 64-bit arithmetic, SV truncating division semantics.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic d0);
        longint sa, sb, r;
        logic [63:0] v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        d0 = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            OpMult: begin
                r = sa * sb;
                v = r;
                {hi, lo} = v;
            end
            OpMultu: begin
                v = {32'd0, a} * {32'd0, b};
                {hi, lo} = v;
            end
            OpDiv, OpDivu: begin
                if (b == 32'd0) begin
                    d0 = 1'b1;
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else if (op == OpDiv) begin
                    r = sa / sb;
                    v = r;
                    lo = v[31:0];
                    r = sa % sb;
                    v = r;
                    hi = v[31:0];
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: ;
        endcase
    endtask

    // Starts at posedge+1; pulses start for one cycle, observes 36 cycles.
    task automatic do_muldiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int st_cyc, output int done_cnt, output int done_at,
                             output logic d0);
        bus.start_E = 1'b1;
        bus.op_E    = op;
        bus.srcA_E  = a;
        bus.srcB_E  = b;
        st_cyc   = 0;
        done_cnt = 0;
        done_at  = -1;
        d0       = 1'b0;
        for (int i = 0; i < 36; i++) begin
            #1;
            if (bus.stall) st_cyc++;
            @(posedge clk);
            #1;
            bus.start_E = 1'b0;
            bus.op_E    = OpNone;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
                d0 = d0 | bus.div0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int st, dc, da, cnt;
        logic d0, ehi_d0;
        logic [31:0] ehi, elo;
        logic [2:0] rop;
        logic [31:0] ra, rb;
        logic released;

        bus.start_E = 1'b0;
        bus.op_E    = OpNone;
        bus.srcA_E  = '0;
        bus.srcB_E  = '0;
        bus.flush_E = 1'b0;

        vecs[0] = '{OpMult,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        vecs[1] = '{OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2] = '{OpDiv,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{OpDivu,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5] = '{OpDiv,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{OpMult,  32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0};
        vecs[7] = '{OpDivu,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
        vecs[8] = '{OpDiv,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[9] = '{OpMult,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};

        // Reset state
        #12;
        check("reset busy", bus.busy, 0);
        check("reset stall", bus.stall, 0);
        check("reset done", bus.done, 0);
        check("reset hi", bus.hi, 0);
        check("reset lo", bus.lo, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table
        foreach (vecs[i]) begin
            do_muldiv(vecs[i].op, vecs[i].a, vecs[i].b, st, dc, da, d0);
            check($sformatf("vec%0d hi", i), bus.hi, vecs[i].hi);
            check($sformatf("vec%0d lo", i), bus.lo, vecs[i].lo);
            check($sformatf("vec%0d div0", i), d0, vecs[i].d0);
            check($sformatf("vec%0d done count", i), dc, 1);
            check($sformatf("vec%0d done cycle", i), da, 33);
            check($sformatf("vec%0d stall cycles", i), st, 34);
        end
        m_hi = vecs[9].hi;
        m_lo = vecs[9].lo;

        // Flush during RUN: no commit, no done
        bus.start_E = 1'b1;
        bus.op_E    = OpMult;
        bus.srcA_E  = 32'd7;
        bus.srcB_E  = 32'd9;
        @(posedge clk);
        #1;
        bus.start_E = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        bus.flush_E = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_E = 1'b0;
        check("flush busy", bus.busy, 0);
        check("flush stall", bus.stall, 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) cnt++;
        end
        check("flush no done", cnt, 0);
        check("flush hi kept", bus.hi, m_hi);
        check("flush lo kept", bus.lo, m_lo);

        // MTHI in IDLE: no stall, written next edge
        bus.start_E = 1'b1;
        bus.op_E    = OpMthi;
        bus.srcA_E  = 32'h0000_1234;
        #1;
        check("mthi stall", bus.stall, 0);
        @(posedge clk);
        #1;
        bus.start_E = 1'b0;
        bus.op_E    = OpNone;
        check("mthi hi", bus.hi, 32'h0000_1234);
        check("mthi lo kept", bus.lo, m_lo);

        // MTLO issued during RUN is held until IDLE
        model(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ehi, elo, ehi_d0);
        bus.start_E = 1'b1;
        bus.op_E    = OpMultu;
        bus.srcA_E  = 32'hFFFF_FFFF;
        bus.srcB_E  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.start_E = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        bus.start_E = 1'b1;
        bus.op_E    = OpMtlo;
        bus.srcA_E  = 32'h0000_ABCD;
        cnt = 0;
        released = 1'b0;
        for (int i = 0; i < 60; i++) begin
            logic s;
            #1;
            s = bus.stall;
            if (s) cnt++;
            @(posedge clk);
            #1;
            if (!s) begin
                released = 1'b1;
                break;
            end
        end
        bus.start_E = 1'b0;
        bus.op_E    = OpNone;
        check("mtlo released", released, 1);
        check("mtlo held cycles", cnt, 28);
        check("mtlo lo", bus.lo, 32'h0000_ABCD);
        check("mtlo hi from multu", bus.hi, ehi);

        // Asynchronous reset mid-RUN
        bus.start_E = 1'b1;
        bus.op_E    = OpMult;
        bus.srcA_E  = 32'd11;
        bus.srcB_E  = 32'd13;
        @(posedge clk);
        #1;
        bus.start_E = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst busy", bus.busy, 0);
        check("rst hi", bus.hi, 0);
        check("rst lo", bus.lo, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_muldiv(OpMult, 32'd3, 32'd5, st, dc, da, d0);
        check("post-rst mult lo", bus.lo, 32'd15);
        check("post-rst mult hi", bus.hi, 32'd0);

        // Back-to-back: second op accepted in the done cycle
        bus.start_E = 1'b1;
        bus.op_E    = OpDivu;
        bus.srcA_E  = 32'd1000;
        bus.srcB_E  = 32'd33;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            bus.start_E = 1'b0;
            if (bus.done) break;
        end
        check("b2b first done", bus.done, 1);
        check("b2b first lo", bus.lo, 32'd30);
        check("b2b first hi", bus.hi, 32'd10);
        do_muldiv(OpMult, 32'hFFFF_FFFD, 32'd7, st, dc, da, d0);
        check("b2b second lo", bus.lo, 32'hFFFF_FFEB);
        check("b2b second hi", bus.hi, 32'hFFFF_FFFF);
        check("b2b second stall", st, 34);

        // Random ops vs model
        for (int n = 0; n < 120; n++) begin
            rop = 3'(1 + $urandom_range(3));
            ra  = ($urandom_range(7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(9))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(15);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, ehi, elo, ehi_d0);
            do_muldiv(rop, ra, rb, st, dc, da, d0);
            check($sformatf("rand%0d op%0d %h,%h hi", n, rop, ra, rb), bus.hi, ehi);
            check($sformatf("rand%0d op%0d %h,%h lo", n, rop, ra, rb), bus.lo, elo);
            check($sformatf("rand%0d op%0d %h,%h div0", n, rop, ra, rb), d0, ehi_d0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
